// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter:
// FSM states, strobe levels and the latched grant bundle.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD
    } arb_state_t;

    localparam logic STB_ON  = 1'b0;
    localparam logic STB_OFF = 1'b1;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
    } strobe_t;

    localparam strobe_t STB_IDLE = '{
        ce_n: STB_OFF,
        oe_n: STB_OFF,
        we_n: STB_OFF
    };

    typedef struct packed {
        logic        port_d;
        logic [15:0] addr;
        logic [15:0] wdata;
    } grant_t;

    // SRAM pin levels for the cycle spent in state s.
    function automatic strobe_t strobes_of(arb_state_t s);
        strobe_t r;
        r = STB_IDLE;
        unique case (s)
            RD: begin
                r.ce_n = STB_ON;
                r.oe_n = STB_ON;
            end
            WR_SETUP: begin
                r.ce_n = STB_ON;
            end
            WR_STROBE: begin
                r.ce_n = STB_ON;
                r.we_n = STB_ON;
            end
            WR_HOLD: begin
                r.ce_n = STB_ON;
            end
            default: r = STB_IDLE;
        endcase
        return r;
    endfunction

    function automatic arb_state_t first_state(logic we);
        return we ? WR_SETUP : RD;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side request/ack bundle of the SRAM arbiter:
// one fetch (read-only) port and one data (read/write) port.
interface mem_arbiter_if;

    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_data;

    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;

    modport master (
        output i_req,
        output i_addr,
        input  i_ack,
        input  i_data,
        output d_req,
        output d_we,
        output d_addr,
        output d_wdata,
        input  d_ack,
        input  d_rdata
    );

    modport slave (
        input  i_req,
        input  i_addr,
        output i_ack,
        output i_data,
        input  d_req,
        input  d_we,
        input  d_addr,
        input  d_wdata,
        output d_ack,
        output d_rdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of an asynchronous SRAM:
// fetch and data ports share one bus, data wins unless fetch was starved.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned READ_WAIT = 0,
    parameter logic [1:0]  ADDR_HI   = 2'b00
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  cpu,
    inout  wire  [15:0]   dataBus,
    output logic [17:0]   addrBus,
    output logic          memRead,
    output logic          memWrite,
    output logic          memEnable
);

    if (READ_WAIT > 3) begin : g_bad_wait
        $error("READ_WAIT must be in 0..3");
    end

    localparam logic [1:0] RW_LAST = READ_WAIT[1:0];

    arb_state_t  state;
    grant_t      cur;
    strobe_t     stb;
    logic [1:0]  wcnt;
    logic        fair;
    logic        oe;

    logic        i_pend;
    logic        d_pend;
    logic        pick_i;
    logic        pick_d;

    // A port is deaf during its own ack cycle.
    assign i_pend = cpu.i_req & ~cpu.i_ack;
    assign d_pend = cpu.d_req & ~cpu.d_ack;

    assign pick_i = i_pend & (fair | ~d_pend);
    assign pick_d = d_pend & ~pick_i;

    assign addrBus   = {ADDR_HI, cur.addr};
    assign memEnable = stb.ce_n;
    assign memRead   = stb.oe_n;
    assign memWrite  = stb.we_n;
    assign dataBus   = oe ? cur.wdata : 16'hzzzz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur         <= '0;
            stb         <= STB_IDLE;
            wcnt        <= '0;
            fair        <= 1'b0;
            oe          <= 1'b0;
            cpu.i_ack   <= 1'b0;
            cpu.d_ack   <= 1'b0;
            cpu.i_data  <= '0;
            cpu.d_rdata <= '0;
        end else begin
            cpu.i_ack <= 1'b0;
            cpu.d_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        pick_d: begin
                            cur <= '{
                                port_d: 1'b1,
                                addr:   cpu.d_addr,
                                wdata:  cpu.d_wdata
                            };
                            fair  <= i_pend;
                            wcnt  <= '0;
                            oe    <= cpu.d_we;
                            state <= first_state(cpu.d_we);
                            stb   <= strobes_of(first_state(cpu.d_we));
                        end
                        pick_i: begin
                            cur <= '{
                                port_d: 1'b0,
                                addr:   cpu.i_addr,
                                wdata:  16'h0000
                            };
                            fair  <= 1'b0;
                            wcnt  <= '0;
                            oe    <= 1'b0;
                            state <= RD;
                            stb   <= strobes_of(RD);
                        end
                        default: ;
                    endcase
                end
                RD: begin
                    if (wcnt == RW_LAST) begin
                        state <= IDLE;
                        stb   <= STB_IDLE;
                        if (cur.port_d) begin
                            cpu.d_rdata <= dataBus;
                            cpu.d_ack   <= 1'b1;
                        end else begin
                            cpu.i_data  <= dataBus;
                            cpu.i_ack   <= 1'b1;
                        end
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                WR_SETUP: begin
                    state <= WR_STROBE;
                    stb   <= strobes_of(WR_STROBE);
                end
                WR_STROBE: begin
                    state <= WR_HOLD;
                    stb   <= strobes_of(WR_HOLD);
                end
                WR_HOLD: begin
                    state     <= IDLE;
                    stb       <= STB_IDLE;
                    oe        <= 1'b0;
                    cpu.d_ack <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    stb   <= STB_IDLE;
                    oe    <= 1'b0;
                end
            endcase
        end
    end

endmodule
